// File: rtl/sa_pkg.sv
// -----------------------------------------------------------------------------
// sa_pkg
//   Shared types and elaboration helpers for the systolic-array operand
//   streamer: FSM state encoding, K-counter width, skew depth and a generic
//   counter-width helper.
// -----------------------------------------------------------------------------
package sa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_FLUSH,
        ST_DONE
    } sa_st_e;

    // Width able to hold 0..k_max inclusive (runtime K depth).
    function automatic int unsigned sa_kw(input int unsigned k_max);
        return $clog2(k_max + 1);
    endfunction

    // Deepest skew lane: the wider edge of the array minus lane 0.
    function automatic int unsigned sa_skw(input int unsigned x_r, input int unsigned w_c);
        return ((x_r > w_c) ? x_r : w_c) - 1;
    endfunction

    // Width able to hold 0..n-1, never below one bit.
    function automatic int unsigned sa_cw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// -----------------------------------------------------------------------------
// sa_skew_line
//   Shift-enabled delay line of DEPTH registers for one array lane. Data only
//   moves when I_EN is high; DEPTH == 0 degenerates to a plain wire.
// Ports
//   I_CLK       clock, rising edge
//   I_SYNC_RST  synchronous active-high reset, clears every stage
//   I_EN        advance strobe
//   I_DATA      lane input
//   O_DATA      lane output, DEPTH advances later
// -----------------------------------------------------------------------------
module sa_skew_line #(
    parameter int unsigned D_W   = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic           I_CLK,
    input  logic           I_SYNC_RST,
    input  logic           I_EN,
    input  logic [D_W-1:0] I_DATA,
    output logic [D_W-1:0] O_DATA
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{I_CLK, I_SYNC_RST, I_EN};
        assign O_DATA      = I_DATA;
    end else begin : g_regs
        logic [DEPTH-1:0][D_W-1:0] stage_q;

        always_ff @(posedge I_CLK) begin
            if (I_SYNC_RST) begin
                stage_q <= '0;
            end else if (I_EN) begin
                stage_q[0] <= I_DATA;
                for (int unsigned d = 1; d < DEPTH; d++) begin
                    stage_q[d] <= stage_q[d-1];
                end
            end
        end

        assign O_DATA = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/sa_operand_streamer.sv
// -----------------------------------------------------------------------------
// sa_operand_streamer
//   Feeds a systolic PE array from the X/W tile buffers. After a start
//   handshake it presents one k-slice per I_PE_SHIFT: X column k on the X lanes
//   and W row k on the W lanes, k ascending (I_REV=0) or descending (I_REV=1),
//   for a runtime depth K (saturated to K_MAX). O_OVER pulses once at the end.
//
//   Build option SA_OPERAND_SKEW_EN: X lane i / W lane j are delayed by i / j
//   shift-enabled registers so the array edge sees a diagonal wavefront; a
//   FLUSH phase of max(X_R,W_C)-1 shifts drains the skew before completion.
//   Without it all lanes are aligned, no skew registers exist and FLUSH is
//   never entered.
//
// Ports
//   I_CLK        clock, rising edge
//   I_SYNC_RST   synchronous active-high reset (aborts a running job)
//   I_START_VLD  job request
//   O_START_RDY  job accept, high only in IDLE
//   I_K_DIM      inner dimension, sampled at fire
//   I_REV        k order select, sampled at fire
//   I_PE_SHIFT   array advance strobe
//   I_X_MATRIX   X tile [X_R][K_MAX], stable for the whole job
//   I_W_MATRIX   W tile [K_MAX][W_C], stable for the whole job
//   O_X_VECTOR   X lane data
//   O_W_VECTOR   W lane data
//   O_VLD        lane-0 data is a real k-slice
//   O_BUSY       job in progress
//   O_OVER       one-cycle job-complete pulse
// -----------------------------------------------------------------------------
module sa_operand_streamer
    import sa_pkg::*;
#(
    parameter  int unsigned D_W   = 8,
    parameter  int unsigned X_R   = 16,
    parameter  int unsigned W_C   = 16,
    parameter  int unsigned K_MAX = 128,
    localparam int unsigned KW    = sa_kw(K_MAX)
) (
    input  logic                              I_CLK,
    input  logic                              I_SYNC_RST,
    input  logic                              I_START_VLD,
    output logic                              O_START_RDY,
    input  logic [KW-1:0]                     I_K_DIM,
    input  logic                              I_REV,
    input  logic                              I_PE_SHIFT,
    input  logic [X_R-1:0][K_MAX-1:0][D_W-1:0] I_X_MATRIX,
    input  logic [K_MAX-1:0][W_C-1:0][D_W-1:0] I_W_MATRIX,
    output logic [X_R-1:0][D_W-1:0]            O_X_VECTOR,
    output logic [W_C-1:0][D_W-1:0]            O_W_VECTOR,
    output logic                              O_VLD,
    output logic                              O_BUSY,
    output logic                              O_OVER
);

    localparam int unsigned IW = sa_cw(K_MAX);

    sa_st_e        state_q, state_d;
    logic [KW-1:0] s_q, s_d;
    logic [KW-1:0] k_len_q, k_len_d;
    logic          rev_q, rev_d;

    logic          fire;
    logic          last_slice;
    logic [KW-1:0] k_sat;
    logic [KW-1:0] k_sel;
    logic [IW-1:0] k_idx;
    logic          unused_k_sel;

    logic [X_R-1:0][D_W-1:0] x_src;
    logic [W_C-1:0][D_W-1:0] w_src;

`ifdef SA_OPERAND_SKEW_EN
    localparam int unsigned SKW = sa_skw(X_R, W_C);
    localparam int unsigned FW  = sa_cw(SKW);

    logic [FW-1:0] f_q, f_d;
`endif

    assign O_START_RDY = (state_q == ST_IDLE);
    assign fire        = I_START_VLD & O_START_RDY;
    assign k_sat       = (I_K_DIM > KW'(K_MAX)) ? KW'(K_MAX) : I_K_DIM;
    assign last_slice  = (s_q == k_len_q - KW'(1));

    // k < K <= K_MAX, so the low IW bits are always a valid tile index.
    assign k_sel        = rev_q ? (k_len_q - KW'(1) - s_q) : s_q;
    assign k_idx        = k_sel[IW-1:0];
    assign unused_k_sel = ^k_sel;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_len_d = k_len_q;
        rev_d   = rev_q;
`ifdef SA_OPERAND_SKEW_EN
        f_d     = f_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A shift in the fire cycle is deliberately ignored.
                if (fire) begin
                    s_d     = '0;
                    k_len_d = k_sat;
                    rev_d   = I_REV;
                    state_d = (k_sat == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (I_PE_SHIFT) begin
                    if (last_slice) begin
                        s_d     = '0;
`ifdef SA_OPERAND_SKEW_EN
                        state_d = (SKW == 0) ? ST_DONE : ST_FLUSH;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        s_d = s_q + KW'(1);
                    end
                end
            end
            ST_FLUSH: begin
`ifdef SA_OPERAND_SKEW_EN
                if (I_PE_SHIFT) begin
                    if (f_q == FW'(SKW - 1)) begin
                        f_d     = '0;
                        state_d = ST_DONE;
                    end else begin
                        f_d = f_q + FW'(1);
                    end
                end
`else
                state_d = ST_DONE;
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RST) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            k_len_q <= '0;
            rev_q   <= 1'b0;
`ifdef SA_OPERAND_SKEW_EN
            f_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_len_q <= k_len_d;
            rev_q   <= rev_d;
`ifdef SA_OPERAND_SKEW_EN
            f_q     <= f_d;
`endif
        end
    end

    // Lane-0 sources are zero outside STREAM so the skew lines drain zeros.
    always_comb begin
        x_src = '0;
        w_src = '0;
        if (state_q == ST_STREAM) begin
            for (int unsigned i = 0; i < X_R; i++) begin
                x_src[i] = I_X_MATRIX[i][k_idx];
            end
            for (int unsigned j = 0; j < W_C; j++) begin
                w_src[j] = I_W_MATRIX[k_idx][j];
            end
        end
    end

    assign O_VLD  = (state_q == ST_STREAM);
    assign O_BUSY = (state_q != ST_IDLE);
    assign O_OVER = (state_q == ST_DONE);

`ifdef SA_OPERAND_SKEW_EN
    for (genvar i = 0; i < X_R; i++) begin : g_x_skew
        sa_skew_line #(
            .D_W  (D_W),
            .DEPTH(i)
        ) u_x_skew (
            .I_CLK     (I_CLK),
            .I_SYNC_RST(I_SYNC_RST),
            .I_EN      (I_PE_SHIFT),
            .I_DATA    (x_src[i]),
            .O_DATA    (O_X_VECTOR[i])
        );
    end
    for (genvar j = 0; j < W_C; j++) begin : g_w_skew
        sa_skew_line #(
            .D_W  (D_W),
            .DEPTH(j)
        ) u_w_skew (
            .I_CLK     (I_CLK),
            .I_SYNC_RST(I_SYNC_RST),
            .I_EN      (I_PE_SHIFT),
            .I_DATA    (w_src[j]),
            .O_DATA    (O_W_VECTOR[j])
        );
    end
`else
    assign O_X_VECTOR = x_src;
    assign O_W_VECTOR = w_src;
`endif

endmodule
